// File: rtl/game_pkg.sv
// Shared types for the game sequencer: FSM state encoding and the default frequency-step word.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        DONE      = 3'd4
    } state_e;

    localparam int FSTEP_WIDTH = 32;

    typedef logic [FSTEP_WIDTH-1:0] fstep_t;

endpackage

// File: rtl/tick_counter.sv
// Modulo-N counter with enable and synchronous clear.
// tick_o is high on the enabled cycle in which the count wraps back to zero.
module tick_counter #(
    parameter int count_p = 10
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (count_p > 1) ? $clog2(count_p) : 1;
    localparam logic [W-1:0] LAST = W'(count_p - 1);

    logic [W-1:0] r_cnt;
    logic         w_term;

    assign w_term = (r_cnt == LAST);
    assign tick_o = en_i && w_term;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Start/countdown/play sequencer: counts down in seconds, then steps through a
// loadable pattern of DDS frequency steps, one note per beat, with pause and loop.
module game_sequencer
    import game_pkg::*;
#(
    parameter int fstep_width_p     = $bits(fstep_t),
    parameter int depth_p           = 16,
    parameter int cycles_per_sec_p  = 22_727_272,
    parameter int cycles_per_beat_p = 5_681_818,
    parameter int countdown_s_p     = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       startbutton_i,
    input  logic                       pause_i,
    input  logic                       loop_i,
    input  logic [$clog2(depth_p):0]   len_i,
    input  logic                       wr_v_i,
    input  logic [$clog2(depth_p)-1:0] wr_addr_i,
    input  logic [fstep_width_p-1:0]   wr_data_i,
    output logic [fstep_width_p-1:0]   fstep_o,
    output logic                       second_o,
    output logic [$clog2(depth_p)-1:0] note_idx_o,
    output logic [2:0]                 state_o,
    output logic                       done_o
);

    localparam int AW    = $clog2(depth_p);
    localparam int LEN_W = AW + 1;
    localparam int CDW   = $clog2(countdown_s_p + 1);

    state_e                   r_state;
    state_e                   w_next_state;
    logic                     r_start_prev;
    logic [AW-1:0]            r_note_idx;
    logic [AW-1:0]            r_last_idx;
    logic [CDW-1:0]           r_cd_cnt;
    logic [fstep_width_p-1:0] r_fstep;
    logic [fstep_width_p-1:0] r_mem [depth_p];

    logic          w_start_edge;
    logic          w_clr;
    logic          w_sec_en;
    logic          w_beat_en;
    logic          w_sec_tick;
    logic          w_beat_tick;
    logic [AW-1:0] w_eff_last;

    assign w_start_edge = startbutton_i && !r_start_prev;
    assign w_clr        = (r_state == IDLE) && w_start_edge;
    assign w_sec_en     = (r_state == COUNTDOWN) || (r_state == PLAY);
    assign w_beat_en    = (r_state == PLAY);

    // A length of 0 or anything beyond the memory means "play the whole memory".
    assign w_eff_last = (len_i == '0 || len_i > LEN_W'(depth_p)) ?
                        AW'(depth_p - 1) : AW'(len_i - 1'b1);

    tick_counter #(.count_p(cycles_per_sec_p)) u_sec_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .en_i     (w_sec_en),
        .clr_i    (w_clr),
        .tick_o   (w_sec_tick)
    );

    tick_counter #(.count_p(cycles_per_beat_p)) u_beat_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .en_i     (w_beat_en),
        .clr_i    (w_clr),
        .tick_o   (w_beat_tick)
    );

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:      if (w_start_edge) w_next_state = COUNTDOWN;
            COUNTDOWN: if (w_sec_tick && r_cd_cnt == CDW'(countdown_s_p - 1)) w_next_state = PLAY;
            PLAY: begin
                // Finishing the pattern wins over a pause request in the same cycle.
                if (w_beat_tick && r_note_idx == r_last_idx && !loop_i) w_next_state = DONE;
                else if (pause_i)                                      w_next_state = PAUSE;
            end
            PAUSE:     if (!pause_i) w_next_state = PLAY;
            DONE:      w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= IDLE;
            r_start_prev <= 1'b1;
            r_note_idx   <= '0;
            r_last_idx   <= '0;
            r_cd_cnt     <= '0;
            r_fstep      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_start_prev <= startbutton_i;
            if (w_clr) begin
                r_note_idx <= '0;
                r_last_idx <= w_eff_last;
                r_cd_cnt   <= '0;
            end else begin
                if (r_state == COUNTDOWN && w_sec_tick) r_cd_cnt <= r_cd_cnt + 1'b1;
                if (w_beat_tick) r_note_idx <= (r_note_idx == r_last_idx) ? '0 : r_note_idx + 1'b1;
            end
            r_fstep <= (r_state == PLAY) ? r_mem[r_note_idx] : '0;
        end
    end

    // Pattern memory is deliberately not reset so a loaded tune survives a game reset.
    always_ff @(posedge clk_i) begin
        if (wr_v_i) r_mem[wr_addr_i] <= wr_data_i;
    end

    assign fstep_o    = r_fstep;
    assign second_o   = w_sec_tick;
    assign note_idx_o = r_note_idx;
    assign state_o    = r_state;
    assign done_o     = (r_state == DONE);

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised bench for game_sequencer: a cycle-level behavioural model of the game rules
// is compared against the DUT on every cycle, plus hand-computed checkpoints.
module tb_game_sequencer;

    localparam int SEC   = 10;
    localparam int BEAT  = 4;
    localparam int CDS   = 3;
    localparam int DEPTH = 4;

    localparam int S_IDLE  = 0;
    localparam int S_CD    = 1;
    localparam int S_PLAY  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b1;
    logic        startbutton_i = 1'b0;
    logic        pause_i = 1'b0;
    logic        loop_i = 1'b0;
    logic [2:0]  len_i = 3'd4;
    logic        wr_v_i = 1'b0;
    logic [1:0]  wr_addr_i = 2'd0;
    logic [31:0] wr_data_i = 32'd0;
    logic [31:0] fstep_o;
    logic        second_o;
    logic [1:0]  note_idx_o;
    logic [2:0]  state_o;
    logic        done_o;

    int checks = 0;
    int failures = 0;
    bit cmpOn = 1'b0;
    bit countOn = 1'b0;
    int count200 = 0;

    // Behavioural model of the game, advanced once per clock edge.
    int          mState;
    int          mSecPhase;
    int          mCdTicks;
    int          mBeat;
    int          mIdx;
    int          mLen;
    logic [31:0] mFstep;
    logic        mPrevStart;
    logic [31:0] mMem [DEPTH];

    game_sequencer #(
        .fstep_width_p    (32),
        .depth_p          (DEPTH),
        .cycles_per_sec_p (SEC),
        .cycles_per_beat_p(BEAT),
        .countdown_s_p    (CDS)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .startbutton_i(startbutton_i),
        .pause_i      (pause_i),
        .loop_i       (loop_i),
        .len_i        (len_i),
        .wr_v_i       (wr_v_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .fstep_o      (fstep_o),
        .second_o     (second_o),
        .note_idx_o   (note_idx_o),
        .state_o      (state_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState     = S_IDLE;
        mSecPhase  = 0;
        mCdTicks   = 0;
        mBeat      = 0;
        mIdx       = 0;
        mLen       = DEPTH;
        mFstep     = 32'd0;
        mPrevStart = 1'b1;
    endtask

    task automatic modelStep();
        int  nxt;
        bit  startEdge;
        startEdge = startbutton_i && !mPrevStart;
        mFstep = (mState == S_PLAY) ? mMem[mIdx] : 32'd0;
        nxt = mState;
        case (mState)
            S_IDLE: if (startEdge) begin
                nxt       = S_CD;
                mSecPhase = 0;
                mCdTicks  = 0;
                mBeat     = 0;
                mIdx      = 0;
                mLen      = (len_i == 0 || int'(len_i) > DEPTH) ? DEPTH : int'(len_i);
            end
            S_CD: begin
                if (mSecPhase == SEC - 1) begin
                    mCdTicks++;
                    if (mCdTicks == CDS) nxt = S_PLAY;
                end
                mSecPhase = (mSecPhase + 1) % SEC;
            end
            S_PLAY: begin
                mSecPhase = (mSecPhase + 1) % SEC;
                mBeat++;
                if (mBeat == BEAT) begin
                    mBeat = 0;
                    if (mIdx == mLen - 1) begin
                        mIdx = 0;
                        if (!loop_i) nxt = S_DONE;
                    end else begin
                        mIdx++;
                    end
                end
                if (nxt != S_DONE && pause_i) nxt = S_PAUSE;
            end
            S_PAUSE: if (!pause_i) nxt = S_PLAY;
            default: nxt = S_IDLE;
        endcase
        if (wr_v_i) mMem[wr_addr_i] = wr_data_i;
        mPrevStart = startbutton_i;
        mState     = nxt;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk_i or negedge reset_ni);
            if (!reset_ni) modelReset();
            else           modelStep();
        end
    end

    // Compare every DUT output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (cmpOn) begin
                checkOutput("state",    32'(state_o),    32'(mState));
                checkOutput("fstep",    fstep_o,         mFstep);
                checkOutput("note_idx", 32'(note_idx_o), 32'(mIdx));
                checkOutput("second",   32'(second_o),
                            32'((mState == S_CD || mState == S_PLAY) && mSecPhase == SEC - 1));
                checkOutput("done",     32'(done_o),     32'(mState == S_DONE));
            end
            if (countOn && fstep_o == 32'h200) count200++;
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic l, input logic [2:0] len);
        startbutton_i = s;
        pause_i       = p;
        loop_i        = l;
        len_i         = len;
    endtask

    task automatic loadEntry(input logic [1:0] addr, input logic [31:0] data);
        wr_v_i    = 1'b1;
        wr_addr_i = addr;
        wr_data_i = data;
        stepCycles(1);
        wr_v_i    = 1'b0;
    endtask

    task automatic asyncReset();
        #2 reset_ni = 1'b0;
        #1;
        checkOutput("async_rst_state", 32'(state_o), 32'd0);
        checkOutput("async_rst_fstep", fstep_o, 32'd0);
        checkOutput("async_rst_done",  32'(done_o), 32'd0);
        stepCycles(1);
        reset_ni = 1'b1;
        stepCycles(2);
    endtask

    initial begin
        // Scenario 1: reset with the button held high.
        startbutton_i = 1'b1;
        #1 reset_ni = 1'b0;
        stepCycles(2);
        reset_ni = 1'b1;
        cmpOn = 1'b1;
        stepCycles(6);
        checkOutput("held_button_state", 32'(state_o), 32'd0);
        checkOutput("reset_idx", 32'(note_idx_o), 32'd0);
        startbutton_i = 1'b0;
        loadEntry(2'd0, 32'h100);
        loadEntry(2'd1, 32'h200);
        loadEntry(2'd2, 32'h300);
        loadEntry(2'd3, 32'h400);
        stepCycles(2);

        // Scenario 2: one pass of four notes.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd4);
        stepCycles(1);
        checkOutput("s2_countdown", 32'(state_o), 32'd1);
        startbutton_i = 1'b0;
        stepCycles(9);
        checkOutput("s2_first_second", 32'(second_o), 32'd1);
        stepCycles(22);
        checkOutput("s2_note0", fstep_o, 32'h100);
        stepCycles(4);
        checkOutput("s2_note1", fstep_o, 32'h200);
        stepCycles(11);
        checkOutput("s2_done", 32'(done_o), 32'd1);
        checkOutput("s2_last_note", fstep_o, 32'h400);
        stepCycles(1);
        checkOutput("s2_idle", 32'(state_o), 32'd0);
        checkOutput("s2_silent", fstep_o, 32'd0);
        stepCycles(3);

        // Scenario 3: loop of two notes, left by an asynchronous reset.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd2);
        stepCycles(1);
        startbutton_i = 1'b0;
        stepCycles(39);
        checkOutput("s3_loop_note0", fstep_o, 32'h100);
        stepCycles(30);
        asyncReset();

        // Scenario 4: pause for 7 cycles in the middle of the second note.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd4);
        countOn = 1'b1;
        stepCycles(1);
        startbutton_i = 1'b0;
        stepCycles(35);
        pause_i = 1'b1;
        stepCycles(4);
        checkOutput("s4_pause_state", 32'(state_o), 32'd3);
        checkOutput("s4_pause_silent", fstep_o, 32'd0);
        stepCycles(3);
        pause_i = 1'b0;
        stepCycles(11);
        checkOutput("s4_done_late", 32'(done_o), 32'd1);
        stepCycles(2);
        countOn = 1'b0;
        checkOutput("s4_note1_length", 32'(count200), 32'd4);
        stepCycles(2);

        // Scenario 5: len 0 plays everything; a start during play is ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
        stepCycles(1);
        startbutton_i = 1'b0;
        stepCycles(39);
        startbutton_i = 1'b1;
        stepCycles(2);
        startbutton_i = 1'b0;
        stepCycles(5);
        checkOutput("s5_done_len0", 32'(done_o), 32'd1);
        stepCycles(3);

        // Scenario 6: rewrite entry 2 while entry 1 plays, then reset mid-play.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd4);
        stepCycles(1);
        startbutton_i = 1'b0;
        stepCycles(35);
        loadEntry(2'd2, 32'h999);
        stepCycles(3);
        checkOutput("s6_rewritten", fstep_o, 32'h999);
        asyncReset();

        // Randomised play, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0) ? ~startbutton_i : 1'b0,
                          ($urandom_range(0, 15) == 0) ? ~pause_i : pause_i,
                          ($urandom_range(0, 63) == 0) ? ~loop_i : loop_i,
                          ($urandom_range(0, 31) == 0) ? 3'($urandom_range(0, 7)) : len_i);
            wr_v_i    = ($urandom_range(0, 9) == 0);
            wr_addr_i = 2'($urandom_range(0, 3));
            wr_data_i = $urandom;
            if ($urandom_range(0, 599) == 0) reset_ni = 1'b0;
            else                             reset_ni = 1'b1;
            stepCycles(1);
        end
        reset_ni = 1'b1;
        wr_v_i   = 1'b0;
        stepCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
